// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if: groups the UART byte stream, instruction-memory write port and load status
//   rx_done/rx_data            : byte strobe and data from the UART receiver
//   mem_we/mem_addr/mem_wdata  : instruction-memory write port
//   cpu_hold/load_busy/load_done/load_error : CPU reset hold and load status
//   master : host/UART side (drives rx, observes results)
//   slave  : the loader
interface uart_program_loader_if #(
    parameter int BYTE_WIDTH  = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8
);
    logic                   rx_done;
    logic [BYTE_WIDTH-1:0]  rx_data;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [INSTR_WIDTH-1:0] mem_wdata;
    logic                   cpu_hold;
    logic                   load_busy;
    logic                   load_done;
    logic                   load_error;

    modport master (
        output rx_done, rx_data,
        input  mem_we, mem_addr, mem_wdata, cpu_hold, load_busy, load_done, load_error
    );

    modport slave (
        input  rx_done, rx_data,
        output mem_we, mem_addr, mem_wdata, cpu_hold, load_busy, load_done, load_error
    );
endinterface

// File: rtl/uart_program_loader.sv
// uart_program_loader: parses a framed program image from UART bytes and writes it into instruction memory
//   clk    : system clock
//   arst_n : asynchronous active-low reset
//   bus    : slave side of uart_program_loader_if (rx byte stream in, memory write + status out)
module uart_program_loader #(
    parameter int BYTE_WIDTH     = 8,
    parameter int INSTR_WIDTH    = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic clk,
    input logic arst_n,
    uart_program_loader_if.slave bus
);
    localparam int BPW       = INSTR_WIDTH / BYTE_WIDTH;
    localparam int BIW       = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int CW        = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;
    localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MAX_WORDS = (2 ** ADDR_WIDTH < 255) ? 2 ** ADDR_WIDTH : 255;

    typedef enum logic [1:0] {IDLE, COUNT, DATA, CHECK} state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          r_word_idx;
    logic [BIW-1:0]         r_byte_idx;
    logic [BYTE_WIDTH-1:0]  r_acc;
    logic [INSTR_WIDTH-1:0] r_word;
    logic [TW-1:0]          r_timer;
    logic                   r_mem_we;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [INSTR_WIDTH-1:0] r_mem_wdata;
    logic                   r_cpu_hold;
    logic                   r_load_busy;
    logic                   r_load_done;
    logic                   r_load_error;

    // Current word with the incoming byte merged in at its little-endian position.
    logic [INSTR_WIDTH-1:0] w_word;
    logic                   w_last_byte;
    logic                   w_timeout;

    assign w_word      = r_word | (INSTR_WIDTH'(bus.rx_data) << (BYTE_WIDTH * int'(r_byte_idx)));
    assign w_last_byte = r_byte_idx == BIW'(BPW - 1);
    assign w_timeout   = (r_state != IDLE) && !bus.rx_done && r_timer == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_word_idx   <= '0;
            r_byte_idx   <= '0;
            r_acc        <= '0;
            r_word       <= '0;
            r_timer      <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_hold   <= 1'b0;
            r_load_busy  <= 1'b0;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_mem_we    <= 1'b0;
            r_load_done <= 1'b0;
            r_timer     <= (bus.rx_done || r_state == IDLE) ? '0 : r_timer + TW'(1);
            if (w_timeout) begin
                // cpu_hold stays high: memory may be partially written
                r_load_error <= 1'b1;
                r_load_busy  <= 1'b0;
                r_state      <= IDLE;
            end else if (bus.rx_done) begin
                case (r_state)
                    IDLE: begin
                        if (bus.rx_data == BYTE_WIDTH'(8'hA5)) begin
                            r_load_error <= 1'b0;
                            r_load_busy  <= 1'b1;
                            r_cpu_hold   <= 1'b1;
                            r_state      <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (bus.rx_data == '0 || int'(bus.rx_data) > MAX_WORDS) begin
                            r_load_error <= 1'b1;
                            r_load_busy  <= 1'b0;
                            r_state      <= IDLE;
                        end else begin
                            r_count    <= CW'(bus.rx_data);
                            r_word_idx <= '0;
                            r_byte_idx <= '0;
                            r_acc      <= '0;
                            r_word     <= '0;
                            r_state    <= DATA;
                        end
                    end
                    DATA: begin
                        r_acc <= r_acc ^ bus.rx_data;
                        if (w_last_byte) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_word_idx[ADDR_WIDTH-1:0];
                            r_mem_wdata <= w_word;
                            r_word      <= '0;
                            r_byte_idx  <= '0;
                            r_word_idx  <= r_word_idx + CW'(1);
                            if (r_word_idx == r_count - CW'(1)) r_state <= CHECK;
                        end else begin
                            r_word     <= w_word;
                            r_byte_idx <= r_byte_idx + BIW'(1);
                        end
                    end
                    CHECK: begin
                        if (bus.rx_data == r_acc) begin
                            r_load_done <= 1'b1;
                            r_cpu_hold  <= 1'b0;
                        end else begin
                            r_load_error <= 1'b1;
                        end
                        r_load_busy <= 1'b0;
                        r_state     <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.cpu_hold   = r_cpu_hold;
    assign bus.load_busy  = r_load_busy;
    assign bus.load_done  = r_load_done;
    assign bus.load_error = r_load_error;
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: directed checks of frame parsing, memory writes, errors, timeout and reset
module tb_uart_program_loader;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   we_cnt = 0;
    int   done_cnt = 0;
    int   we_snap;
    int   done_snap;

    uart_program_loader_if #(.BYTE_WIDTH(8), .INSTR_WIDTH(32), .ADDR_WIDTH(8)) bus ();

    uart_program_loader #(
        .BYTE_WIDTH(8), .INSTR_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we) we_cnt++;
        if (bus.load_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle strobe; returns #1 after the capturing edge so registered results are visible.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.rx_done = 1'b1;
        bus.rx_data = b;
        @(posedge clk);
        #1 bus.rx_done = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, " mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, " cpu_hold"}, 32'(bus.cpu_hold), 32'd0);
        chk({tag, " load_busy"}, 32'(bus.load_busy), 32'd0);
        chk({tag, " load_done"}, 32'(bus.load_done), 32'd0);
        chk({tag, " load_error"}, 32'(bus.load_error), 32'd0);
    endtask

    initial begin
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1 chk_reset_values("reset");
        @(negedge clk) arst_n = 1'b1;

        // Single word DEADBEEF, checksum 22
        send(8'hA5);
        chk("hdr busy", 32'(bus.load_busy), 32'd1);
        chk("hdr hold", 32'(bus.cpu_hold), 32'd1);
        send(8'h01); send(8'hEF); send(8'hBE); send(8'hAD);
        chk("w1 no we early", 32'(bus.mem_we), 32'd0);
        send(8'hDE);
        chk("w1 we", 32'(bus.mem_we), 32'd1);
        chk("w1 addr", 32'(bus.mem_addr), 32'h00);
        chk("w1 wdata", bus.mem_wdata, 32'hDEADBEEF);
        send(8'h22);
        chk("w1 we drop", 32'(bus.mem_we), 32'd0);
        chk("w1 done", 32'(bus.load_done), 32'd1);
        chk("w1 hold", 32'(bus.cpu_hold), 32'd0);
        chk("w1 busy", 32'(bus.load_busy), 32'd0);
        chk("w1 err", 32'(bus.load_error), 32'd0);
        @(posedge clk); #1;
        chk("w1 done pulse", 32'(bus.load_done), 32'd0);
        chk("w1 wdata held", bus.mem_wdata, 32'hDEADBEEF);

        // Two words
        send(8'hA5); send(8'h02);
        send(8'h01); send(8'h00); send(8'h00); send(8'h00);
        chk("w2a we", 32'(bus.mem_we), 32'd1);
        chk("w2a addr", 32'(bus.mem_addr), 32'h00);
        chk("w2a wdata", bus.mem_wdata, 32'h00000001);
        send(8'h02); send(8'h00); send(8'h00); send(8'h00);
        chk("w2b we", 32'(bus.mem_we), 32'd1);
        chk("w2b addr", 32'(bus.mem_addr), 32'h01);
        chk("w2b wdata", bus.mem_wdata, 32'h00000002);
        send(8'h03);
        chk("w2 done", 32'(bus.load_done), 32'd1);

        // Bad checksum, then recovery
        send(8'hA5); send(8'h01); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        chk("bad we", 32'(bus.mem_we), 32'd1);
        chk("bad addr", 32'(bus.mem_addr), 32'h00);
        send(8'h23);
        chk("bad err", 32'(bus.load_error), 32'd1);
        chk("bad hold", 32'(bus.cpu_hold), 32'd1);
        chk("bad done", 32'(bus.load_done), 32'd0);
        chk("bad busy", 32'(bus.load_busy), 32'd0);
        send(8'hA5);
        chk("rec err clr", 32'(bus.load_error), 32'd0);
        send(8'h01); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE); send(8'h22);
        chk("rec done", 32'(bus.load_done), 32'd1);
        chk("rec hold", 32'(bus.cpu_hold), 32'd0);

        // Count zero
        we_snap = we_cnt;
        send(8'hA5); send(8'h00);
        chk("cnt0 err", 32'(bus.load_error), 32'd1);
        chk("cnt0 busy", 32'(bus.load_busy), 32'd0);
        chk("cnt0 hold", 32'(bus.cpu_hold), 32'd1);
        chk("cnt0 no we", 32'(we_cnt), 32'(we_snap));

        // Timeout after 100 idle cycles
        we_snap = we_cnt;
        send(8'hA5); send(8'h01); send(8'hEF);
        chk("to err clr", 32'(bus.load_error), 32'd0);
        repeat (99) @(posedge clk);
        #1;
        chk("to not yet", 32'(bus.load_error), 32'd0);
        chk("to busy still", 32'(bus.load_busy), 32'd1);
        @(posedge clk); #1;
        chk("to err", 32'(bus.load_error), 32'd1);
        chk("to busy", 32'(bus.load_busy), 32'd0);
        chk("to hold", 32'(bus.cpu_hold), 32'd1);
        chk("to no we", 32'(we_cnt), 32'(we_snap));

        // Noise in IDLE
        we_snap = we_cnt;
        done_snap = done_cnt;
        send(8'h00); send(8'hFF); send(8'h5A);
        @(posedge clk); #1;
        chk("noise busy", 32'(bus.load_busy), 32'd0);
        chk("noise err", 32'(bus.load_error), 32'd1);
        chk("noise no we", 32'(we_cnt), 32'(we_snap));
        chk("noise no done", 32'(done_cnt), 32'(done_snap));

        // Header byte as data: word 000000A5 with checksum A5
        send(8'hA5); send(8'h01); send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        chk("hdat wdata", bus.mem_wdata, 32'h000000A5);
        send(8'hA5);
        chk("hdat done", 32'(bus.load_done), 32'd1);

        // Reset mid-frame
        send(8'hA5); send(8'h01); send(8'hEF);
        chk("mid busy", 32'(bus.load_busy), 32'd1);
        #2 arst_n = 1'b0;
        #1 chk_reset_values("midrst");
        @(negedge clk) arst_n = 1'b1;
        send(8'h01);
        chk("post rst idle", 32'(bus.load_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
